// File: rtl/key_debounce_multi.sv
// N-channel key conditioner: 2-flop synchroniser, debounced level, press/release/long strobes.
// Optional auto-repeat strobe in the HELD state is built only when KEY_REPEAT_EN is defined.
module key_debounce_multi #(
  parameter int NUM_KEYS      = 2,
  parameter int CLK_FREQ_HZ   = 50_000_000,
  parameter int DEBOUNCE_MS   = 10,
  parameter int LONG_PRESS_MS = 1000,
  parameter int REPEAT_MS     = 100,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic                Sys_CLK,
  input  logic                Sys_RST_N,
  input  logic [NUM_KEYS-1:0] Key_In,
  output logic [NUM_KEYS-1:0] Key_Out,
  output logic [NUM_KEYS-1:0] Key_Press,
  output logic [NUM_KEYS-1:0] Key_Release,
  output logic [NUM_KEYS-1:0] Key_Long,
  output logic [NUM_KEYS-1:0] Key_Repeat
);

  localparam int DB_CNT   = CLK_FREQ_HZ / 1000 * DEBOUNCE_MS;
  localparam int LONG_CNT = CLK_FREQ_HZ / 1000 * LONG_PRESS_MS;
  localparam int DB_W     = $clog2(DB_CNT);
  localparam int LONG_W   = $clog2(LONG_CNT);

  localparam logic [DB_W-1:0]     DB_LAST   = DB_W'(DB_CNT - 1);
  localparam logic [LONG_W-1:0]   LONG_LAST = LONG_W'(LONG_CNT - 1);
  localparam logic [NUM_KEYS-1:0] IDLE_LVL  = (ACTIVE_LOW != 0) ? '1 : '0;

  if (NUM_KEYS < 1 || NUM_KEYS > 16 || DB_CNT < 2 || LONG_CNT <= DB_CNT || REPEAT_MS < 1) begin : g_param_check
    $error("key_debounce_multi: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    ST_RELEASED = 2'd0,
    ST_PRESSED  = 2'd1,
    ST_HELD     = 2'd2
  } state_t;

  logic [NUM_KEYS-1:0] r_sync0;
  logic [NUM_KEYS-1:0] r_sync1;
  logic [NUM_KEYS-1:0] w_pressed;

  // Synchronisers reset to the released pin level so reset exit never looks like a press.
  always_ff @(posedge Sys_CLK or negedge Sys_RST_N) begin
    if (!Sys_RST_N) begin
      r_sync0 <= IDLE_LVL;
      r_sync1 <= IDLE_LVL;
    end else begin
      r_sync0 <= Key_In;
      r_sync1 <= r_sync0;
    end
  end

  assign w_pressed = r_sync1 ^ IDLE_LVL;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    logic [DB_W-1:0]   r_db_cnt;
    logic              r_out;
    logic              w_toggle;
    state_t            r_state;
    logic [LONG_W-1:0] r_hold_cnt;
    logic              r_press;
    logic              r_release;
    logic              r_long;

    assign w_toggle = (w_pressed[g] != r_out) && (r_db_cnt == DB_LAST);

    always_ff @(posedge Sys_CLK or negedge Sys_RST_N) begin
      if (!Sys_RST_N) begin
        r_db_cnt <= '0;
        r_out    <= 1'b0;
      end else if (w_pressed[g] == r_out) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_out    <= ~r_out;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end

    // Release takes priority over the long-press check when both land on one edge.
    always_ff @(posedge Sys_CLK or negedge Sys_RST_N) begin
      if (!Sys_RST_N) begin
        r_state    <= ST_RELEASED;
        r_hold_cnt <= '0;
        r_press    <= 1'b0;
        r_release  <= 1'b0;
        r_long     <= 1'b0;
      end else begin
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_long    <= 1'b0;
        case (r_state)
          ST_RELEASED: begin
            if (w_toggle && !r_out) begin
              r_press    <= 1'b1;
              r_hold_cnt <= '0;
              r_state    <= ST_PRESSED;
            end
          end
          ST_PRESSED: begin
            if (w_toggle && r_out) begin
              r_release <= 1'b1;
              r_state   <= ST_RELEASED;
            end else if (r_hold_cnt == LONG_LAST) begin
              r_long  <= 1'b1;
              r_state <= ST_HELD;
            end else begin
              r_hold_cnt <= r_hold_cnt + 1'b1;
            end
          end
          ST_HELD: begin
            if (w_toggle && r_out) begin
              r_release <= 1'b1;
              r_state   <= ST_RELEASED;
            end
          end
          default: r_state <= ST_RELEASED;
        endcase
      end
    end

    assign Key_Out[g]     = r_out;
    assign Key_Press[g]   = r_press;
    assign Key_Release[g] = r_release;
    assign Key_Long[g]    = r_long;

`ifdef KEY_REPEAT_EN
    localparam int REPEAT_CNT = CLK_FREQ_HZ / 1000 * REPEAT_MS;
    localparam int REP_W      = (REPEAT_CNT > 1) ? $clog2(REPEAT_CNT) : 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CNT - 1);

    logic [REP_W-1:0] r_rep_cnt;
    logic             r_repeat;

    // Counter runs only while HELD and not on the releasing edge, so it restarts fresh on every hold.
    always_ff @(posedge Sys_CLK or negedge Sys_RST_N) begin
      if (!Sys_RST_N) begin
        r_rep_cnt <= '0;
        r_repeat  <= 1'b0;
      end else begin
        r_repeat <= 1'b0;
        if (r_state == ST_HELD && !(w_toggle && r_out)) begin
          if (r_rep_cnt == REP_LAST) begin
            r_rep_cnt <= '0;
            r_repeat  <= 1'b1;
          end else begin
            r_rep_cnt <= r_rep_cnt + 1'b1;
          end
        end else begin
          r_rep_cnt <= '0;
        end
      end
    end

    assign Key_Repeat[g] = r_repeat;
`else
    assign Key_Repeat[g] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Scoreboard bench for key_debounce_multi: a timestamp-based reference model queues expected strobes,
// a negedge monitor pops and compares them and checks the debounced level every cycle.
module tb_key_debounce_multi;

  localparam int NK   = 2;
  localparam int DB   = 100;
  localparam int LONG = 500;
  localparam int REP  = 200;
`ifdef KEY_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic          Sys_CLK = 1'b0;
  logic          Sys_RST_N;
  logic [NK-1:0] Key_In;
  logic [NK-1:0] Key_Out;
  logic [NK-1:0] Key_Press;
  logic [NK-1:0] Key_Release;
  logic [NK-1:0] Key_Long;
  logic [NK-1:0] Key_Repeat;

  key_debounce_multi #(
    .NUM_KEYS(NK),
    .CLK_FREQ_HZ(100_000),
    .DEBOUNCE_MS(1),
    .LONG_PRESS_MS(5),
    .REPEAT_MS(2),
    .ACTIVE_LOW(1)
  ) dut (
    .Sys_CLK(Sys_CLK),
    .Sys_RST_N(Sys_RST_N),
    .Key_In(Key_In),
    .Key_Out(Key_Out),
    .Key_Press(Key_Press),
    .Key_Release(Key_Release),
    .Key_Long(Key_Long),
    .Key_Repeat(Key_Repeat)
  );

  always #5 Sys_CLK = ~Sys_CLK;

  typedef struct {
    int cyc;
    int ch;
    int kind;  // 0 press, 1 release, 2 long, 3 repeat
  } ev_t;

  ev_t q[$];
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_err = 0;

  // Reference model state: pin history in "pressed" polarity, level, run length, timestamps.
  bit m_p1[NK];
  bit m_p2[NK];
  bit m_out[NK];
  bit m_down[NK];
  bit m_longed[NK];
  int m_run[NK];
  int m_t_press[NK];
  int m_t_long[NK];

  always @(posedge Sys_CLK) begin
    cyc++;
    for (int ch = 0; ch < NK; ch++) begin
      if (!Sys_RST_N) begin
        m_p1[ch] = 1'b0; m_p2[ch] = 1'b0; m_out[ch] = 1'b0;
        m_down[ch] = 1'b0; m_longed[ch] = 1'b0; m_run[ch] = 0;
        m_t_press[ch] = 0; m_t_long[ch] = 0;
      end else begin
        bit s;
        int evk;
        s = m_p2[ch];
        m_p2[ch] = m_p1[ch];
        m_p1[ch] = ~Key_In[ch];
        evk = -1;
        if (s != m_out[ch]) begin
          m_run[ch]++;
          if (m_run[ch] == DB) begin
            m_out[ch] = s;
            m_run[ch] = 0;
            evk = s ? 0 : 1;
          end
        end else begin
          m_run[ch] = 0;
        end
        if (evk == 0) begin
          m_down[ch] = 1'b1; m_longed[ch] = 1'b0; m_t_press[ch] = cyc;
        end else if (evk == 1) begin
          m_down[ch] = 1'b0;
        end else if (m_down[ch] && !m_longed[ch] && (cyc - m_t_press[ch]) == LONG) begin
          evk = 2; m_longed[ch] = 1'b1; m_t_long[ch] = cyc;
        end else if (REP_EN && m_down[ch] && m_longed[ch] && ((cyc - m_t_long[ch]) % REP) == 0) begin
          evk = 3;
        end
        if (evk >= 0) q.push_back('{cyc: cyc, ch: ch, kind: evk});
      end
    end
  end

  function automatic logic [NK-1:0] strobe(int k);
    case (k)
      0:       return Key_Press;
      1:       return Key_Release;
      2:       return Key_Long;
      default: return Key_Repeat;
    endcase
  endfunction

  always @(negedge Sys_CLK) begin
    if (!Sys_RST_N) begin
      n_cmp++;
      if ({Key_Out, Key_Press, Key_Release, Key_Long, Key_Repeat} != '0) begin
        n_err++;
        $display("FAIL reset_outputs cyc %0d: got out=%b pr=%b rl=%b lg=%b rp=%b want all 0",
                 cyc, Key_Out, Key_Press, Key_Release, Key_Long, Key_Repeat);
      end
    end else begin
      for (int ch = 0; ch < NK; ch++) begin
        n_cmp++;
        if (Key_Out[ch] != m_out[ch]) begin
          n_err++;
          $display("FAIL key_out ch%0d cyc %0d: got %0b want %0b", ch, cyc, Key_Out[ch], m_out[ch]);
        end
        for (int k = 0; k < 4; k++) begin
          logic [NK-1:0] v;
          v = strobe(k);
          if (v[ch]) begin
            n_cmp++;
            if (q.size() == 0 || q[0].cyc != cyc || q[0].ch != ch || q[0].kind != k) begin
              n_err++;
              if (q.size() == 0)
                $display("FAIL strobe ch%0d kind %0d cyc %0d: got pulse want none", ch, k, cyc);
              else
                $display("FAIL strobe ch%0d kind %0d cyc %0d: got pulse want ch%0d kind %0d cyc %0d",
                         ch, k, cyc, q[0].ch, q[0].kind, q[0].cyc);
            end else begin
              void'(q.pop_front());
            end
          end
        end
      end
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        n_cmp++;
        n_err++;
        $display("FAIL missing_strobe ch%0d kind %0d: got none want pulse at cyc %0d",
                 q[0].ch, q[0].kind, q[0].cyc);
        void'(q.pop_front());
      end
    end
  end

  task automatic cycles(int n);
    repeat (n) @(posedge Sys_CLK);
    #2;
  endtask

  initial begin
    Sys_RST_N = 1'b0;
    Key_In    = '1;
    cycles(3);
    Sys_RST_N = 1'b1;
    cycles(1000);

    Key_In[0] = 1'b0;
    cycles(300);
    Key_In[0] = 1'b1;
    cycles(300);

    for (int i = 0; i < 20; i++) begin
      Key_In[1] = ~Key_In[1];
      cycles(50);
    end
    Key_In[1] = 1'b1;
    cycles(200);

    Key_In[0] = 1'b0;
    cycles(1100);
    Key_In[0] = 1'b1;
    cycles(300);

    Key_In = 2'b00;
    cycles(300);
    Key_In[0] = 1'b1;
    cycles(30);
    Key_In[1] = 1'b1;
    cycles(300);

    // Reset while key 0 is down with 300 cycles of hold accumulated.
    Key_In[0] = 1'b0;
    cycles(102 + 300);
    Sys_RST_N = 1'b0;
    cycles(5);
    Sys_RST_N = 1'b1;
    cycles(800);
    Key_In[0] = 1'b1;
    cycles(300);

    for (int i = 0; i < 30; i++) begin
      int dur;
      Key_In = 2'($urandom_range(0, 3));
      dur = ($urandom_range(0, 7) == 0) ? 700 : $urandom_range(1, 150);
      cycles(dur);
    end
    Key_In = '1;
    cycles(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
